interleaver_pingpong_ctrl: RTL and testbench
============================================

// Module: interleaver_pingpong_ctrl
// PURPOSE
//  Ping-pong frame buffer controller behind the bit interleaver. It accepts (bit, permuted index) pairs
//  from the interleaver and writes each bit into one of two Ncbps-bit banks at that index. Each full
//  bank is streamed in ascending address order to the QPSK mapper, so the mapper sees interleaved
//  order. Filling one bank overlaps draining the other, so the FEC->mod path runs at 1 bit/clk.
// PARAMETERS
//  NCBPS   192                 coded bits per OFDM block (bank depth, bits)
//  IDX_W   $clog2(NCBPS)       width of bit index / counters
//  FCNT_W  8                   width of completed-frame counter
// PORTS
//  clk          in   1       single clock; all logic on posedge
//  reset        in   1       asynchronous, active-high reset
//  in_valid     in   1       interleaver output bit valid
//  in_data      in   1       interleaved bit
//  in_index     in   IDX_W   destination address (j) of in_data
//  in_ready     out  1       controller can accept a bit this cycle
//  out_ready    in   1       mapper accepts a bit
//  out_valid    out  1       out_data valid
//  out_data     out  1       bit at current read address of read bank
//  out_last     out  1       out_data is address NCBPS-1 of the frame
//  frames_done  out  FCNT_W  count of fully drained frames, wraps
//  err_range    out  1       sticky: an accepted in_index >= NCBPS
//  err_dup      out  1       sticky: same in_index written twice in one bank fill
// BEHAVIOUR
//  Reset (async, immediate): both banks EMPTY; wr_bank=0, rd_bank=0; wr_cnt=rd_cnt=0; written masks
//   cleared; in_ready=1 after reset deassert; out_valid=0, out_last=0, out_data=0; frames_done=0;
//   err_range=0, err_dup=0. Bank contents need not reset. Reset mid-frame discards all partial and
//   full frames.
//  Per-bank state: EMPTY -> FULL (last write accepted) -> EMPTY (last read accepted). No other states.
//  Write side:
//   - in_ready = (state[wr_bank]==EMPTY); combinational from registers, not from in_valid.
//   - Accept = in_valid && in_ready. On accept: mem[wr_bank][in_index]<=in_data (dropped when index >=
//     NCBPS, and err_range set); set written[wr_bank][in_index]. If that bit is already set, set err_dup
//     and still overwrite. wr_cnt++.
//   - On accept with wr_cnt==NCBPS-1: state[wr_bank]<=FULL, wr_cnt<=0, written[wr_bank] cleared,
//     wr_bank toggles. Completion is by count, not by index coverage.
//  Read side:
//   - out_valid = (state[rd_bank]==FULL); out_data = mem[rd_bank][rd_cnt]; out_last = out_valid &&
//     rd_cnt==NCBPS-1. All are outputs of a registered path with no in_* comb dependence.
//   - Transfer = out_valid && out_ready; rd_cnt++. On transfer with out_last: state[rd_bank]<=EMPTY,
//     rd_cnt<=0, rd_bank toggles, frames_done++ (wraps 2^FCNT_W-1 -> 0).
//   - out_valid/out_data are held stable while out_valid && !out_ready.
//  Latency: last write accepted at edge t -> out_valid=1 in cycle after t. Freed bank -> in_ready=1 in
//   cycle after last read.
//  Simultaneous events: filling bank A and draining bank B in the same cycle are independent. Completing
//   a fill and completing a drain on the same edge both take effect; the state vector updates per bank.
//   Write to the bank being read cannot occur, because in_ready=0 when wr_bank is FULL.
//  Both banks FULL: in_ready=0 and the FEC stalls. Both EMPTY: out_valid=0.
//  Error flags clear only on reset; they never block data flow.
// TESTING
//  1. Reset, stream 192 bits index=k, data=k[0], out_ready=1 -> out_valid rises 1 clk after 192nd accept;
//     192 outputs 0,1,0,1..; out_last on 192nd; frames_done=1.
//  2. Reversed indices (index=191-k, data=k[0]) -> output at addr a equals (191-a)[0]; no errors.
//  3. out_ready=0, feed 384 bits back-to-back -> in_ready low after 384th accept; 385th held; out_data stable;
//     raise out_ready -> 384 bits drained in order, frames_done=2.
//  4. Continuous in_valid=1/out_ready=1 for 10 frames -> in_ready never drops after frame 1;
//     frames_done=10 (frame boundaries overlap fill/drain).
//  5. Index 200 once, and index 5 twice within one frame -> err_range=1, err_dup=1 sticky; frame still
//     completes after 192 accepts.
//  6. Assert reset midway through frame 2 fill while frame 1 drains -> all outputs at reset values
//     immediately; next 192 bits form frame 1 again.

Source files
------------

// File: rtl/interleaver_pingpong_ctrl.sv
// Ping-pong frame buffer between the bit interleaver and the QPSK mapper.
// One bank fills at the permuted index while the other drains in ascending address order.
module interleaver_pingpong_ctrl #(
   parameter int NCBPS  = 192,
   parameter int IDX_W  = $clog2(NCBPS),
   parameter int FCNT_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              in_data,
   input  logic [IDX_W-1:0]  in_index,
   output logic              in_ready,
   input  logic              out_ready,
   output logic              out_valid,
   output logic              out_data,
   output logic              out_last,
   output logic [FCNT_W-1:0] frames_done,
   output logic              err_range,
   output logic              err_dup
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCBPS - 1);
   localparam logic [IDX_W:0]   DEPTH    = (IDX_W + 1)'(NCBPS);

   // bank_full[b]: 0 = EMPTY, 1 = FULL
   logic [1:0]            bank_full, bank_full_nxt;
   logic                  wr_bank, wr_bank_nxt;
   logic                  rd_bank, rd_bank_nxt;
   logic [IDX_W-1:0]      wr_cnt, wr_cnt_nxt;
   logic [IDX_W-1:0]      rd_cnt, rd_cnt_nxt;
   logic [1:0][NCBPS-1:0] written, written_nxt;
   logic [FCNT_W-1:0]     frames_done_nxt;
   logic                  err_range_nxt, err_dup_nxt;
   logic [1:0][NCBPS-1:0] mem;

   logic accept, xfer, in_range;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bank_full   <= '0;
         wr_bank     <= 1'b0;
         rd_bank     <= 1'b0;
         wr_cnt      <= '0;
         rd_cnt      <= '0;
         written     <= '0;
         frames_done <= '0;
         err_range   <= 1'b0;
         err_dup     <= 1'b0;
      end else begin
         bank_full   <= bank_full_nxt;
         wr_bank     <= wr_bank_nxt;
         rd_bank     <= rd_bank_nxt;
         wr_cnt      <= wr_cnt_nxt;
         rd_cnt      <= rd_cnt_nxt;
         written     <= written_nxt;
         frames_done <= frames_done_nxt;
         err_range   <= err_range_nxt;
         err_dup     <= err_dup_nxt;
      end
   end

   // Bank storage carries data only, so it is left out of reset.
   always_ff @(posedge clk) begin
      if (accept && in_range)
         mem[wr_bank][in_index] <= in_data;
   end

   always_comb begin
      in_range        = ({1'b0, in_index} < DEPTH);
      accept          = in_valid && in_ready;
      xfer            = out_valid && out_ready;
      bank_full_nxt   = bank_full;
      wr_bank_nxt     = wr_bank;
      rd_bank_nxt     = rd_bank;
      wr_cnt_nxt      = wr_cnt;
      rd_cnt_nxt      = rd_cnt;
      written_nxt     = written;
      frames_done_nxt = frames_done;
      err_range_nxt   = err_range;
      err_dup_nxt     = err_dup;

      if (accept) begin
         if (in_range) begin
            if (written[wr_bank][in_index])
               err_dup_nxt = 1'b1;
            written_nxt[wr_bank][in_index] = 1'b1;
         end else begin
            err_range_nxt = 1'b1;
         end
         // A bank completes on the NCBPS-th accept regardless of which indices arrived.
         if (wr_cnt == LAST_IDX) begin
            bank_full_nxt[wr_bank] = 1'b1;
            wr_cnt_nxt             = '0;
            written_nxt[wr_bank]   = '0;
            wr_bank_nxt            = ~wr_bank;
         end else begin
            wr_cnt_nxt = wr_cnt + 1'b1;
         end
      end

      // Fill and drain always target different banks, so both updates can land together.
      if (xfer) begin
         if (rd_cnt == LAST_IDX) begin
            bank_full_nxt[rd_bank] = 1'b0;
            rd_cnt_nxt             = '0;
            rd_bank_nxt            = ~rd_bank;
            frames_done_nxt        = frames_done + 1'b1;
         end else begin
            rd_cnt_nxt = rd_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      in_ready  = ~bank_full[wr_bank];
      out_valid = bank_full[rd_bank];
      out_data  = out_valid & mem[rd_bank][rd_cnt];
      out_last  = out_valid && (rd_cnt == LAST_IDX);
   end

endmodule

// File: tb/tb_interleaver_pingpong_ctrl.sv
// Randomized bench for interleaver_pingpong_ctrl against a frame-queue reference model.
module tb_interleaver_pingpong_ctrl;

   localparam int N = 192;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_data = 1'b0;
   logic [7:0] in_index = '0;
   logic       in_ready;
   logic       out_ready = 1'b0;
   logic       out_valid;
   logic       out_data;
   logic       out_last;
   logic [7:0] frames_done;
   logic       err_range;
   logic       err_dup;

   int checks = 0;
   int failures = 0;

   // Reference model: frames as bit vectors, a queue of completed frames awaiting drain.
   logic [N-1:0] cur_bits;
   logic [N-1:0] cur_mask;
   logic [N-1:0] fq_bits[$];
   logic [N-1:0] fq_mask[$];
   int           wcnt, rpos, fdone;
   logic         m_err_range, m_err_dup;

   interleaver_pingpong_ctrl #(.NCBPS(N), .IDX_W(8), .FCNT_W(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_index   (in_index),
      .in_ready   (in_ready),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_last   (out_last),
      .frames_done(frames_done),
      .err_range  (err_range),
      .err_dup    (err_dup)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      cur_bits = '0;
      cur_mask = '0;
      fq_bits.delete();
      fq_mask.delete();
      wcnt = 0;
      rpos = 0;
      fdone = 0;
      m_err_range = 1'b0;
      m_err_dup = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      #1;
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_out_last", 32'(out_last), 32'd0);
      check_eq("rst_out_data", 32'(out_data), 32'd0);
      check_eq("rst_frames", 32'(frames_done), 32'd0);
      check_eq("rst_err_range", 32'(err_range), 32'd0);
      check_eq("rst_err_dup", 32'(err_dup), 32'd0);
      model_clear();
      @(negedge clk);
      @(posedge clk);
      #2;
      reset = 1'b0;
   endtask

   // Drive one cycle at the falling edge, compare outputs, then advance the model to the next rising edge.
   task automatic step(input logic v, input logic d, input logic [7:0] idx, input logic ordy);
      logic exp_ready, exp_valid, acc, xf;
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      in_index  = idx;
      out_ready = ordy;
      exp_ready = (fq_bits.size() < 2);
      exp_valid = (fq_bits.size() > 0);
      check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
      check_eq("out_valid", 32'(out_valid), 32'(exp_valid));
      check_eq("out_last", 32'(out_last), 32'(exp_valid && rpos == N - 1));
      if (exp_valid && fq_mask[0][rpos])
         check_eq("out_data", 32'(out_data), 32'(fq_bits[0][rpos]));
      check_eq("frames_done", 32'(frames_done), 32'(fdone));
      check_eq("err_range", 32'(err_range), 32'(m_err_range));
      check_eq("err_dup", 32'(err_dup), 32'(m_err_dup));

      acc = v && exp_ready;
      xf  = exp_valid && ordy;
      if (xf) begin
         rpos++;
         if (rpos == N) begin
            void'(fq_bits.pop_front());
            void'(fq_mask.pop_front());
            rpos = 0;
            fdone = (fdone + 1) % 256;
         end
      end
      if (acc) begin
         if (int'(idx) < N) begin
            if (cur_mask[idx]) m_err_dup = 1'b1;
            cur_bits[idx] = d;
            cur_mask[idx] = 1'b1;
         end else begin
            m_err_range = 1'b1;
         end
         wcnt++;
         if (wcnt == N) begin
            fq_bits.push_back(cur_bits);
            fq_mask.push_back(cur_mask);
            cur_mask = '0;
            wcnt = 0;
         end
      end
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0, 1'b1);
   endtask

   initial begin
      model_clear();
      do_reset();

      // Straight indices, alternating data
      for (int k = 0; k < N; k++) step(1'b1, k[0], 8'(k), 1'b1);
      drain(N + 4);
      check_eq("t1_frames", 32'(frames_done), 32'd1);

      // Reversed indices: address a carries (191-a)[0]
      for (int k = 0; k < N; k++) step(1'b1, k[0], 8'(N - 1 - k), 1'b1);
      drain(N + 4);
      check_eq("t2_frames", 32'(frames_done), 32'd2);
      check_eq("t2_noerr", 32'(err_range | err_dup), 32'd0);

      // Mapper stalled: two banks fill, 385th bit held, then drain both
      do_reset();
      for (int k = 0; k < 2 * N + 1; k++) step(1'b1, 1'($urandom), 8'(k % N), 1'b0);
      for (int k = 0; k < 2 * N + 8; k++) step(1'b1, 1'($urandom), 8'(k % N), 1'b1);
      drain(2 * N);
      check_eq("t3_frames", 32'(frames_done), 32'd3);

      // Continuous flow for 10 frames with random permutation-like indices
      do_reset();
      for (int f = 0; f < 10; f++)
         for (int k = 0; k < N; k++) step(1'b1, 1'($urandom), 8'((k * 7 + f) % N), 1'b1);
      drain(N + 4);
      check_eq("t4_frames", 32'(frames_done), 32'd10);

      // Out-of-range index once, duplicate index once
      do_reset();
      for (int k = 0; k < N; k++)
         step(1'b1, 1'($urandom), (k == 10) ? 8'd200 : (k == 20) ? 8'd5 : 8'(k), 1'b1);
      drain(N + 4);
      check_eq("t5_err_range", 32'(err_range), 32'd1);
      check_eq("t5_err_dup", 32'(err_dup), 32'd1);
      check_eq("t5_frames", 32'(frames_done), 32'd1);

      // Reset mid-way through frame 2 fill while frame 1 drains
      do_reset();
      for (int k = 0; k < N + 100; k++) step(1'b1, 1'($urandom), 8'(k % N), 1'b1);
      do_reset();
      for (int k = 0; k < N; k++) step(1'b1, 1'($urandom), 8'(N - 1 - k), 1'b1);
      drain(N + 4);
      check_eq("t6_frames", 32'(frames_done), 32'd1);

      // Fully random handshakes, data and indices with occasional out-of-range values
      do_reset();
      for (int i = 0; i < 4000; i++)
         step($urandom_range(0, 3) != 0, 1'($urandom),
              ($urandom_range(0, 99) == 0) ? 8'($urandom_range(192, 255)) : 8'($urandom_range(0, 191)),
              $urandom_range(0, 2) != 0);
      drain(2 * N + 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
